// File: rtl/equiv_stim_checker.sv
// Stimulus/response harness around a unit under test and its golden copy:
// drives LFSR vectors, samples both outputs at the end of each hold window, and reports pass/fail.
`timescale 1ns/1ps
module equiv_stim_checker #(
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned HOLD_CYCLES   = 25,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned CNT_W         = 8,
  parameter bit          STOP_ON_FAIL  = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             dut_out,
  input  logic             ref_out,
  output logic             stim_a,
  output logic             stim_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] mismatch_vec,
  output logic [3:0]       mismatch_data
);
  // An all-zero seed would lock the LFSR up, so substitute 1.
  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] FB_MASK = 16'hB400;
  localparam int unsigned TMAX    = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW      = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(NUM_VECTORS);

  typedef enum logic [1:0] {IDLE, SETTLE, APPLY, DONE} state_t;

  state_t           state, state_next;
  logic [15:0]      lfsr;
  logic [TW-1:0]    timer;
  logic             accept, load_vec, do_check, finish, mismatch;
  logic [CNT_W-1:0] count_inc;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ FB_MASK;
    return nxt;
  endfunction

  // Case inequality so X/Z on either unit is reported as a mismatch in simulation.
  assign mismatch  = (dut_out !== ref_out);
  assign count_inc = vec_count + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_vec   = 1'b0;
    do_check   = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (timer == '0) begin
          load_vec   = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (timer == '0) begin
          do_check = 1'b1;
          if ((mismatch && STOP_ON_FAIL) || (count_inc == LAST_COUNT)) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            load_vec = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr          <= SEED;
      timer         <= '0;
      stim_a        <= 1'b0;
      stim_b        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      vec_count     <= '0;
      mismatch_vec  <= '0;
      mismatch_data <= '0;
    end else if (accept) begin
      lfsr          <= SEED;
      timer         <= SETTLE_LOAD;
      stim_a        <= 1'b0;
      stim_b        <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      vec_count     <= '0;
      mismatch_vec  <= '0;
      mismatch_data <= '0;
    end else begin
      // The vector is taken from the LFSR before it steps.
      if (load_vec) begin
        stim_a <= lfsr[0];
        stim_b <= lfsr[1];
        lfsr   <= lfsr_step(lfsr);
        timer  <= HOLD_LOAD;
      end else if (timer != '0) begin
        timer <= timer - TW'(1);
      end
      if (do_check) begin
        vec_count <= count_inc;
        if (mismatch && !fail) begin
          fail          <= 1'b1;
          mismatch_vec  <= vec_count;
          mismatch_data <= {stim_a, stim_b, dut_out, ref_out};
        end
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= !(fail || mismatch);
      end
    end
  end
endmodule

// File: tb/tb_equiv_stim_checker.sv
// Bench for equiv_stim_checker: three instances (default, no-stop, zero seed) checked every cycle
// against a closed-form run model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_equiv_stim_checker;
  localparam int N    = 3;
  localparam int NV   = 16;
  localparam int HOLD = 25;
  localparam int SET  = 100;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] start_v = '0;
  logic [N-1:0] inj     = '0;
  logic [N-1:0] dut_out_v, ref_out_v, stim_a_v, stim_b_v, busy_v, done_v, pass_v, fail_v;
  logic [7:0]   vec_count_v [N];
  logic [7:0]   mvec_v      [N];
  logic [3:0]   mdata_v     [N];

  always #5 clock = ~clock;

  assign ref_out_v = stim_a_v & stim_b_v;
  assign dut_out_v = ref_out_v ^ inj;

  equiv_stim_checker u_stop (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .dut_out(dut_out_v[0]), .ref_out(ref_out_v[0]),
    .stim_a(stim_a_v[0]), .stim_b(stim_b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail(fail_v[0]), .vec_count(vec_count_v[0]), .mismatch_vec(mvec_v[0]), .mismatch_data(mdata_v[0]));

  equiv_stim_checker #(.STOP_ON_FAIL(1'b0)) u_nostop (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .dut_out(dut_out_v[1]), .ref_out(ref_out_v[1]),
    .stim_a(stim_a_v[1]), .stim_b(stim_b_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail(fail_v[1]), .vec_count(vec_count_v[1]), .mismatch_vec(mvec_v[1]), .mismatch_data(mdata_v[1]));

  equiv_stim_checker #(.LFSR_SEED(16'h0000)) u_seed0 (
    .clock(clock), .reset_n(reset_n), .start(start_v[2]), .dut_out(dut_out_v[2]), .ref_out(ref_out_v[2]),
    .stim_a(stim_a_v[2]), .stim_b(stim_b_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .fail(fail_v[2]), .vec_count(vec_count_v[2]), .mismatch_vec(mvec_v[2]), .mismatch_data(mdata_v[2]));

  // Model state: vector tables, run start edge, injected-fault mask snapshot per run.
  logic [15:0] seed_m [N] = '{16'hACE1, 16'hACE1, 16'h0001};
  bit          stop_m [N] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] mask     [N] = '{default: 16'h0000};
  logic [15:0] run_mask [N] = '{default: 16'h0000};
  logic        va [N][NV];
  logic        vb [N][NV];
  int          run_s     [N] = '{default: 0};
  int          run_epoch [N] = '{default: 0};
  int          rst_epoch = 1;
  int          edge_n    = 0;
  int          checks    = 0;
  int          errors    = 0;
  bit          check_en  = 1'b0;

  typedef struct packed {
    logic       busy, done, pass, fail, a, b;
    logic [7:0] vc, mv;
    logic [3:0] md;
  } exp_t;

  function automatic bit active(input int i);
    return run_epoch[i] == rst_epoch;
  endfunction

  function automatic int first_bad(input int i);
    for (int j = 0; j < NV; j++) if (run_mask[i][j]) return j;
    return NV;
  endfunction

  function automatic int n_checks(input int i);
    int f;
    f = first_bad(i);
    return (stop_m[i] && f < NV) ? f + 1 : NV;
  endfunction

  function automatic int k_end(input int i);
    return SET + n_checks(i) * HOLD;
  endfunction

  function automatic exp_t model(input int i, input int e);
    exp_t x;
    int k, f, nc, j;
    x = '0;
    if (!active(i)) return x;
    k  = e - run_s[i];
    f  = first_bad(i);
    nc = n_checks(i);
    if (k < SET) begin
      x.busy = 1'b1;
      return x;
    end
    if (k < SET + nc * HOLD) begin
      j      = (k - SET) / HOLD;
      x.busy = 1'b1;
      x.vc   = 8'(j);
      x.a    = va[i][j];
      x.b    = vb[i][j];
      x.fail = (f < j);
    end else begin
      x.done = 1'b1;
      x.vc   = 8'(nc);
      x.a    = va[i][nc-1];
      x.b    = vb[i][nc-1];
      x.fail = (f < nc);
      x.pass = !x.fail;
    end
    if (x.fail) begin
      x.mv = 8'(f);
      x.md = {va[i][f], vb[i][f], ~(va[i][f] & vb[i][f]), va[i][f] & vb[i][f]};
    end
    return x;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge %0d: got %0h want %0h", name, i, edge_n, act, exp);
    end
  endtask

  // Run acceptance: a start seen while the modelled run is not busy opens a new run at this edge.
  always @(posedge clock) begin
    edge_n = edge_n + 1;
    for (int i = 0; i < N; i++) begin
      if (reset_n && start_v[i] && !(active(i) && (edge_n - 1 - run_s[i]) < k_end(i))) begin
        run_s[i]     = edge_n;
        run_epoch[i] = rst_epoch;
        run_mask[i]  = mask[i];
      end
    end
  end

  always @(negedge clock) begin
    exp_t x;
    int k;
    for (int i = 0; i < N; i++) begin
      x = model(i, edge_n);
      if (check_en) begin
        chk("busy",      i, 32'(busy_v[i]),      32'(x.busy));
        chk("done",      i, 32'(done_v[i]),      32'(x.done));
        chk("pass",      i, 32'(pass_v[i]),      32'(x.pass));
        chk("fail",      i, 32'(fail_v[i]),      32'(x.fail));
        chk("stim_a",    i, 32'(stim_a_v[i]),    32'(x.a));
        chk("stim_b",    i, 32'(stim_b_v[i]),    32'(x.b));
        chk("vec_count", i, 32'(vec_count_v[i]), 32'(x.vc));
        chk("mism_vec",  i, 32'(mvec_v[i]),      32'(x.mv));
        chk("mism_data", i, 32'(mdata_v[i]),     32'(x.md));
      end
      inj[i] = 1'b0;
      if (active(i)) begin
        k = edge_n - run_s[i];
        if (k >= SET && k < k_end(i)) inj[i] = run_mask[i][(k - SET) / HOLD];
      end
    end
  end

  task automatic wait_k(input int i, input int k);
    int target;
    target = run_s[i] + k;
    do @(negedge clock); while (edge_n < target);
    chk("wait_k", i, 32'(edge_n), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge %0d: got timeout want finish", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l;
    int s_old;
    for (int i = 0; i < N; i++) begin
      l = seed_m[i];
      for (int j = 0; j < NV; j++) begin
        va[i][j] = l[0];
        vb[i][j] = l[1];
        l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      end
    end
    // Pin the vector tables to hand-derived LFSR values (ACE1, E270, 0E27 step; seed-0 path).
    chk("model_v0_a", 0, 32'(va[0][0]), 32'd1);
    chk("model_v1_a", 0, 32'(va[0][1]), 32'd0);
    chk("model_v5_ab", 0, 32'({va[0][5], vb[0][5]}), 32'b11);
    chk("model_seed0_v1", 2, 32'({va[2][1], vb[2][1]}), 32'b00);

    // Power-on reset.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",  0, 32'(busy_v[0]),      32'd0);
    chk("rst_done",  0, 32'(done_v[0]),      32'd0);
    chk("rst_vc",    0, 32'(vec_count_v[0]), 32'd0);
    chk("rst_mdata", 0, 32'(mdata_v[0]),     32'd0);
    reset_n  = 1'b1;
    check_en = 1'b1;

    // Run A, aborted by a short asynchronous reset while vector 5 is applied.
    @(posedge clock); #1 start_v[0] = 1'b1;
    @(posedge clock); #1 start_v[0] = 1'b0;
    wait_k(0, 230);
    chk("preabort_stim_a", 0, 32'(stim_a_v[0]), 32'd1);
    #1 reset_n = 1'b0;
    rst_epoch++;
    #1;
    chk("abort_busy",   0, 32'(busy_v[0]),      32'd0);
    chk("abort_stim_a", 0, 32'(stim_a_v[0]),    32'd0);
    chk("abort_vc",     0, 32'(vec_count_v[0]), 32'd0);
    #2 reset_n = 1'b1;

    // Run B on all three: clean default run, no-stop run with faults on vectors 3 and 9, zero seed.
    mask[0] = 16'h0000;
    mask[1] = 16'h0208;
    mask[2] = 16'h0000;
    @(posedge clock); #1 start_v = 3'b111;
    @(posedge clock); #1 start_v = 3'b000;
    wait_k(0, 0);
    chk("b_busy0", 0, 32'(busy_v[0]), 32'd1);
    wait_k(0, 49);
    start_v[0] = 1'b1;
    @(posedge clock); #1 start_v[0] = 1'b0;
    wait_k(0, 99);
    chk("b_settle_a", 0, 32'(stim_a_v[0]), 32'd0);
    wait_k(0, 100);
    chk("b_v0_ab",    0, 32'({stim_a_v[0], stim_b_v[0]}), 32'b10);
    chk("b_v0_vc",    0, 32'(vec_count_v[0]), 32'd0);
    chk("s0_v0_ab",   2, 32'({stim_a_v[2], stim_b_v[2]}), 32'b10);
    wait_k(0, 124);
    chk("b_v0_hold",  0, 32'({stim_a_v[0], stim_b_v[0]}), 32'b10);
    wait_k(0, 125);
    chk("b_v1_ab",    0, 32'({stim_a_v[0], stim_b_v[0]}), 32'b00);
    chk("b_v1_vc",    0, 32'(vec_count_v[0]), 32'd1);
    chk("s0_v1_ab",   2, 32'({stim_a_v[2], stim_b_v[2]}), 32'b00);
    wait_k(0, 299);
    start_v[0] = 1'b1;
    @(posedge clock); #1 start_v[0] = 1'b0;
    wait_k(0, 499);
    chk("b_done_early", 0, 32'(done_v[0]), 32'd0);
    chk("ns_done_early", 1, 32'(done_v[1]), 32'd0);
    wait_k(0, 500);
    chk("b_done", 0, 32'(done_v[0]),      32'd1);
    chk("b_pass", 0, 32'(pass_v[0]),      32'd1);
    chk("b_vc",   0, 32'(vec_count_v[0]), 32'd16);
    chk("b_busy", 0, 32'(busy_v[0]),      32'd0);
    chk("ns_done",  1, 32'(done_v[1]),      32'd1);
    chk("ns_pass",  1, 32'(pass_v[1]),      32'd0);
    chk("ns_fail",  1, 32'(fail_v[1]),      32'd1);
    chk("ns_mvec",  1, 32'(mvec_v[1]),      32'd3);
    chk("ns_mdata", 1, 32'(mdata_v[1]),     32'b0010);
    chk("ns_vc",    1, 32'(vec_count_v[1]), 32'd16);

    // Restart after done: same sequence again, status cleared on entry.
    wait_k(0, 508);
    s_old = run_s[0];
    start_v[0] = 1'b1;
    @(posedge clock); #1 start_v[0] = 1'b0;
    wait_k(0, 0);
    chk("r_start_edge", 0, 32'(run_s[0] - s_old), 32'd509);
    chk("r_done", 0, 32'(done_v[0]),      32'd0);
    chk("r_pass", 0, 32'(pass_v[0]),      32'd0);
    chk("r_vc",   0, 32'(vec_count_v[0]), 32'd0);
    chk("r_busy", 0, 32'(busy_v[0]),      32'd1);
    wait_k(0, 100);
    chk("r_v0_ab", 0, 32'({stim_a_v[0], stim_b_v[0]}), 32'b10);
    wait_k(0, 500);
    chk("r_pass_end", 0, 32'(pass_v[0]), 32'd1);

    // Run C: fault on vector 5 only, stop on first failure.
    mask[0] = 16'h0020;
    @(posedge clock); #1 start_v[0] = 1'b1;
    @(posedge clock); #1 start_v[0] = 1'b0;
    wait_k(0, 249);
    chk("c_done_early", 0, 32'(done_v[0]), 32'd0);
    wait_k(0, 250);
    chk("c_done",  0, 32'(done_v[0]),      32'd1);
    chk("c_fail",  0, 32'(fail_v[0]),      32'd1);
    chk("c_pass",  0, 32'(pass_v[0]),      32'd0);
    chk("c_mvec",  0, 32'(mvec_v[0]),      32'd5);
    chk("c_vc",    0, 32'(vec_count_v[0]), 32'd6);
    chk("c_mdata", 0, 32'(mdata_v[0]),     32'b1101);
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
